// File: rtl/upd1771c_pkg.sv
// upd1771c_pkg
// Shared types and constants for the uPD1771C host command sequencer.
//   state_e        : sequencer states (IDLE, WAIT_RDY, ALIGN, HOLD, GAP)
//   DEF_*_PHI2     : default hold / gap / ready-timeout lengths in PHI2 ticks
//   BUS_IDLE       : value driven on the core's PA input when no byte is held
//   max3()         : helper used to size the shared PHI2 down-counter
package upd1771c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    ALIGN    = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4
  } state_e;

  localparam int unsigned DEF_HOLD_PHI2 = 10;
  localparam int unsigned DEF_GAP_PHI2  = 2;
  localparam int unsigned DEF_TMO_PHI2  = 4096;

  localparam logic [7:0] BUS_IDLE = 8'h00;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/upd1771c_cmd_seq_if.sv
// upd1771c_cmd_seq_if
// Bus bundle between the host-side glue / sound core and the command sequencer.
//   CKEN   : sequencer clock enable (FIFO writes ignore it)
//   PHI2P  : one-CLK PHI2 phase strobe from the sound core
//   WR     : host write strobe, WDATA : host command byte
//   RDY    : core ready level
//   DOUT   : byte on the core PA input, DVALID : DOUT carries a command
//   FULL / EMPTY : FIFO flags
//   OVF    : sticky, a host write was dropped
//   TMO    : sticky, a byte was dropped on ready timeout
// master = host/core side driving the inputs, slave = the sequencer.
interface upd1771c_cmd_seq_if;

  logic       CKEN;
  logic       PHI2P;
  logic       WR;
  logic [7:0] WDATA;
  logic       RDY;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       FULL;
  logic       EMPTY;
  logic       OVF;
  logic       TMO;

  modport master (
    output CKEN, PHI2P, WR, WDATA, RDY,
    input  DOUT, DVALID, FULL, EMPTY, OVF, TMO
  );

  modport slave (
    input  CKEN, PHI2P, WR, WDATA, RDY,
    output DOUT, DVALID, FULL, EMPTY, OVF, TMO
  );

endinterface

// File: rtl/upd1771c_cmd_fifo.sv
// upd1771c_cmd_fifo
// Synchronous show-ahead FIFO for host command bytes.
//   CLK, RESB : clock, asynchronous active-low reset (pointers/count only)
//   i_wr      : write request; ignored while full
//   i_wdata   : byte to store
//   i_pop     : pop request; ignored while empty
//   o_rdata   : current head (valid whenever o_empty is 0)
//   o_full    : DEPTH entries stored
//   o_empty   : no entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
module upd1771c_cmd_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RESB,
  input  logic       i_wr,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          w_push;
  logic          w_pop;

  // Flags come from registered state, so a write at full is refused even
  // when a pop happens in the same cycle.
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_wr  & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are unreachable once pointers clear.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/upd1771c_cmd_seq.sv
// upd1771c_cmd_seq
// Host-side command sequencer for the uPD1771C sound core. Host bytes are
// queued in a FIFO; each byte waits for RDY, is aligned to a PHI2 tick,
// driven on DOUT for HOLD_PHI2 ticks, then followed by GAP_PHI2 idle ticks.
//   CLK, RESB : system clock, asynchronous active-low reset
//   bus       : upd1771c_cmd_seq_if.slave (CKEN, PHI2P, WR, WDATA, RDY in;
//               DOUT, DVALID, FULL, EMPTY, OVF, TMO out)
// Build option: UPD1771C_CMD_SEQ_TIMEOUT_EN enables the ready-wait timeout
// (drop the held byte and set TMO after TMO_PHI2 ticks without RDY).
// Without it WAIT_RDY waits forever and TMO is tied 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing in flight; pops the FIFO head when not empty
// WAIT_RDY | byte held, waiting for RDY (optionally with timeout)
// ALIGN    | RDY seen; waiting for the next PHI2 tick to drive DOUT
// HOLD     | DOUT driven, counting HOLD_PHI2 ticks
// GAP      | DOUT idle, counting GAP_PHI2 ticks before the next byte
module upd1771c_cmd_seq
  import upd1771c_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned HOLD_PHI2 = DEF_HOLD_PHI2,
  parameter int unsigned GAP_PHI2  = DEF_GAP_PHI2,
  parameter int unsigned TMO_PHI2  = DEF_TMO_PHI2
) (
  input  logic              CLK,
  input  logic              RESB,
  upd1771c_cmd_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(max3(HOLD_PHI2, GAP_PHI2, TMO_PHI2) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_hold;
  logic [7:0]       w_hold_nxt;
  logic [7:0]       r_dout;
  logic [7:0]       w_dout_nxt;
  logic             r_dvalid;
  logic             w_dvalid_nxt;
  logic             r_ovf;

  logic             w_tick;
  logic             w_pop;
  logic [7:0]       w_head;
  logic             w_full;
  logic             w_empty;

`ifdef UPD1771C_CMD_SEQ_TIMEOUT_EN
  logic             r_tmo;
  logic             w_tmo_set;
`endif

  assign w_tick = bus.PHI2P & bus.CKEN;

  upd1771c_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESB    (RESB),
    .i_wr    (bus.WR),
    .i_wdata (bus.WDATA),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hold   <= BUS_IDLE;
      r_dout   <= BUS_IDLE;
      r_dvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hold   <= w_hold_nxt;
      r_dout   <= w_dout_nxt;
      r_dvalid <= w_dvalid_nxt;
    end
  end

  // Everything below is gated by CKEN so a low enable freezes the FSM and
  // its counter; PHI2 strobes during the freeze are simply lost.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hold_nxt   = r_hold;
    w_dout_nxt   = r_dout;
    w_dvalid_nxt = r_dvalid;
    w_pop        = 1'b0;
`ifdef UPD1771C_CMD_SEQ_TIMEOUT_EN
    w_tmo_set    = 1'b0;
`endif
    if (bus.CKEN) begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_hold_nxt  = w_head;
            w_state_nxt = WAIT_RDY;
`ifdef UPD1771C_CMD_SEQ_TIMEOUT_EN
            w_cnt_nxt   = CNT_W'(TMO_PHI2);
`endif
          end
        end
        WAIT_RDY: begin
          // A tick in this cycle is never used for alignment: ALIGN only
          // looks at ticks from the next cycle on.
          if (bus.RDY) begin
            w_state_nxt = ALIGN;
          end
`ifdef UPD1771C_CMD_SEQ_TIMEOUT_EN
          else if (w_tick) begin
            if (r_cnt <= CNT_ONE) begin
              w_tmo_set   = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
`endif
        end
        ALIGN: begin
          if (w_tick) begin
            w_dout_nxt   = r_hold;
            w_dvalid_nxt = 1'b1;
            w_cnt_nxt    = CNT_W'(HOLD_PHI2);
            w_state_nxt  = HOLD;
          end
        end
        HOLD: begin
          // RDY is deliberately ignored here; the hold always runs full length.
          if (w_tick) begin
            if (r_cnt <= CNT_ONE) begin
              w_dout_nxt   = BUS_IDLE;
              w_dvalid_nxt = 1'b0;
              if (GAP_PHI2 == 0) begin
                w_state_nxt = IDLE;
              end else begin
                w_cnt_nxt   = CNT_W'(GAP_PHI2);
                w_state_nxt = GAP;
              end
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
        end
        GAP: begin
          if (w_tick) begin
            if (r_cnt <= CNT_ONE) begin
              w_state_nxt = IDLE;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Overflow tracks host writes, which are independent of CKEN.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_ovf <= 1'b0;
    end else if (bus.WR && w_full) begin
      r_ovf <= 1'b1;
    end
  end

`ifdef UPD1771C_CMD_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_tmo <= 1'b0;
    end else if (w_tmo_set) begin
      r_tmo <= 1'b1;
    end
  end

  assign bus.TMO = r_tmo;
`else
  assign bus.TMO = 1'b0;
`endif

  assign bus.DOUT   = r_dout;
  assign bus.DVALID = r_dvalid;
  assign bus.FULL   = w_full;
  assign bus.EMPTY  = w_empty;
  assign bus.OVF    = r_ovf;

endmodule

// File: tb/tb_upd1771c_cmd_seq.sv
// tb_upd1771c_cmd_seq
// Directed bench for upd1771c_cmd_seq. PHI2P strobes once every 4 CLK.
// DOUT/DVALID changes are logged with the count of enabled PHI2 ticks, so
// hold/gap lengths are checked in PHI2 periods. The timeout scenario runs
// only when UPD1771C_CMD_SEQ_TIMEOUT_EN is defined.
module tb_upd1771c_cmd_seq;

  typedef struct {
    int         tick;
    logic [7:0] d;
    logic       v;
  } ev_t;

  logic CLK;
  logic RESB;
  upd1771c_cmd_seq_if bus ();

  upd1771c_cmd_seq #(
    .DEPTH     (8),
    .HOLD_PHI2 (10),
    .GAP_PHI2  (2),
    .TMO_PHI2  (16)
  ) dut (
    .CLK  (CLK),
    .RESB (RESB),
    .bus  (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   tick     = 0;
  int   phase    = 0;
  ev_t  ev_q[$];
  logic [7:0] prev_d = 8'h00;
  logic       prev_v = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    bus.PHI2P = 1'b0;
    forever begin
      @(negedge CLK);
      phase     = (phase + 1) % 4;
      bus.PHI2P = (phase == 0);
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      if (bus.PHI2P && bus.CKEN && RESB) tick = tick + 1;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (bus.DOUT !== prev_d || bus.DVALID !== prev_v) begin
        ev_q.push_back('{tick: tick, d: bus.DOUT, v: bus.DVALID});
        prev_d = bus.DOUT;
        prev_v = bus.DVALID;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int evt(input int k);
    if (k < ev_q.size()) return ev_q[k].tick;
    return -1000;
  endfunction

  function automatic logic [8:0] evd(input int k);
    if (k < ev_q.size()) return {ev_q[k].v, ev_q[k].d};
    return 9'h1FF;
  endfunction

  task automatic write_byte(input logic [7:0] d);
    bus.WR    = 1'b1;
    bus.WDATA = d;
    @(negedge CLK);
    bus.WR    = 1'b0;
  endtask

  // Returns at the negedge right after a posedge that sampled an enabled tick.
  task automatic sync_tick();
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK);
      if (bus.PHI2P && bus.CKEN) break;
    end
    @(negedge CLK);
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = tick;
    for (int i = 0; i < n * 8 + 16 && tick < t0 + n; i++) @(negedge CLK);
  endtask

  task automatic wait_events(input int n, input string tag);
    for (int i = 0; i < 2000 && ev_q.size() < n; i++) @(negedge CLK);
    chk(tag, ev_q.size() >= n, 1);
  endtask

  initial begin
    int t0;
    RESB      = 1'b1;
    bus.CKEN  = 1'b1;
    bus.WR    = 1'b0;
    bus.WDATA = 8'h00;
    bus.RDY   = 1'b0;
    #2 RESB = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_dout",   bus.DOUT, 8'h00);
    chk("rst_dvalid", bus.DVALID, 1'b0);
    chk("rst_full",   bus.FULL, 1'b0);
    chk("rst_empty",  bus.EMPTY, 1'b1);
    chk("rst_ovf",    bus.OVF, 1'b0);
    chk("rst_tmo",    bus.TMO, 1'b0);
    RESB = 1'b1;
    repeat (2) @(negedge CLK);
    ev_q.delete();

    // Single byte 0F with RDY high, write issued right after a tick.
    bus.RDY = 1'b1;
    sync_tick();
    t0 = tick;
    write_byte(8'h0F);
    chk("single_empty_after_wr", bus.EMPTY, 1'b0);
    @(negedge CLK);
    chk("single_empty_after_pop", bus.EMPTY, 1'b1);
    wait_events(2, "single_events_timeout");
    chk("single_start_tick", evt(0), t0 + 1);
    chk("single_start_data", evd(0), {1'b1, 8'h0F});
    chk("single_hold_len",   evt(1) - evt(0), 10);
    chk("single_end_data",   evd(1), {1'b0, 8'h00});
    wait_ticks(6);
    chk("single_no_extra", ev_q.size(), 2);
    ev_q.delete();

    // Burst 01,02,03 back-to-back.
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    wait_events(6, "burst_events_timeout");
    chk("burst_b0", evd(0), {1'b1, 8'h01});
    chk("burst_b1", evd(2), {1'b1, 8'h02});
    chk("burst_b2", evd(4), {1'b1, 8'h03});
    chk("burst_end", evd(5), {1'b0, 8'h00});
    chk("burst_hold0", evt(1) - evt(0), 10);
    chk("burst_hold2", evt(5) - evt(4), 10);
    chk("burst_gap01", evt(2) - evt(1), 3);
    chk("burst_space01", evt(2) - evt(0), 13);
    chk("burst_space12", evt(4) - evt(2), 13);
    wait_ticks(4);
    ev_q.delete();

    // CKEN freeze mid-hold; a FIFO write during the freeze still lands.
    write_byte(8'h77);
    wait_events(1, "freeze_start_timeout");
    repeat (2) @(negedge CLK);
    bus.CKEN = 1'b0;
    write_byte(8'h78);
    chk("freeze_wr_empty", bus.EMPTY, 1'b0);
    repeat (20) @(negedge CLK);
    chk("freeze_dout",   bus.DOUT, 8'h77);
    chk("freeze_dvalid", bus.DVALID, 1'b1);
    chk("freeze_no_pop", bus.EMPTY, 1'b0);
    bus.CKEN = 1'b1;
    wait_events(4, "freeze_events_timeout");
    chk("freeze_hold_len", evt(1) - evt(0), 10);
    chk("freeze_next_data", evd(2), {1'b1, 8'h78});
    chk("freeze_next_space", evt(2) - evt(0), 13);
    wait_ticks(4);
    ev_q.delete();

    // Ready gating: 55 waits 50 ticks, then aligns on the next tick.
    bus.RDY = 1'b0;
    write_byte(8'h55);
    wait_ticks(50);
    chk("gate_no_output", ev_q.size(), 0);
    chk("gate_dout",      bus.DOUT, 8'h00);
    chk("gate_empty",     bus.EMPTY, 1'b1);
    sync_tick();
    t0 = tick;
    bus.RDY = 1'b1;
    wait_events(2, "gate_events_timeout");
    chk("gate_start_tick", evt(0), t0 + 1);
    chk("gate_start_data", evd(0), {1'b1, 8'h55});
    chk("gate_hold_len",   evt(1) - evt(0), 10);
    wait_ticks(4);
    ev_q.delete();

    // RDY sampled on the same CLK as a tick: that tick is skipped.
    bus.RDY = 1'b0;
    write_byte(8'h56);
    wait_ticks(3);
    sync_tick();
    repeat (3) @(negedge CLK);
    t0 = tick;
    bus.RDY = 1'b1;
    wait_events(2, "collide_events_timeout");
    chk("collide_start_tick", evt(0), t0 + 2);
    chk("collide_start_data", evd(0), {1'b1, 8'h56});
    wait_ticks(4);
    ev_q.delete();

    // Overflow: 9 writes fill the FIFO (one byte held), 10th is dropped.
    bus.RDY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.WR    = 1'b1;
      bus.WDATA = 8'h10 + 8'(i);
      @(negedge CLK);
      if (i == 7) chk("ovf_not_full_8", bus.FULL, 1'b0);
      if (i == 8) begin
        chk("ovf_full_9", bus.FULL, 1'b1);
        chk("ovf_clear_9", bus.OVF, 1'b0);
      end
    end
    bus.WR = 1'b0;
    chk("ovf_set", bus.OVF, 1'b1);
    chk("ovf_still_full", bus.FULL, 1'b1);
    bus.RDY = 1'b1;
    wait_events(18, "ovf_events_timeout");
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("ovf_byte%0d", i), evd(2 * i), {1'b1, 8'h10 + 8'(i)});
    end
    wait_ticks(20);
    chk("ovf_dropped_absent", ev_q.size(), 18);
    chk("ovf_drained", bus.EMPTY, 1'b1);
    chk("ovf_sticky", bus.OVF, 1'b1);
    ev_q.delete();

    // Reset in the middle of a hold.
    sync_tick();
    write_byte(8'h0F);
    wait_events(1, "rst_start_timeout");
    repeat (8) @(negedge CLK);
    RESB = 1'b0;
    #1;
    chk("midrst_dout",   bus.DOUT, 8'h00);
    chk("midrst_dvalid", bus.DVALID, 1'b0);
    chk("midrst_empty",  bus.EMPTY, 1'b1);
    chk("midrst_ovf",    bus.OVF, 1'b0);
    repeat (3) @(negedge CLK);
    RESB = 1'b1;
    ev_q.delete();
    wait_ticks(40);
    chk("midrst_quiet", ev_q.size(), 0);
    write_byte(8'h3C);
    wait_events(2, "midrst_new_timeout");
    chk("midrst_new_data", evd(0), {1'b1, 8'h3C});
    chk("midrst_new_hold", evt(1) - evt(0), 10);
    wait_ticks(4);
    ev_q.delete();

`ifdef UPD1771C_CMD_SEQ_TIMEOUT_EN
    // Timeout: AA never driven, BB afterwards goes out normally.
    bus.RDY = 1'b0;
    write_byte(8'hAA);
    wait_ticks(8);
    chk("tmo_early", bus.TMO, 1'b0);
    wait_ticks(12);
    chk("tmo_set",      bus.TMO, 1'b1);
    chk("tmo_no_out",   ev_q.size(), 0);
    chk("tmo_empty",    bus.EMPTY, 1'b1);
    bus.RDY = 1'b1;
    write_byte(8'hBB);
    wait_events(2, "tmo_next_timeout");
    chk("tmo_next_data", evd(0), {1'b1, 8'hBB});
    chk("tmo_next_hold", evt(1) - evt(0), 10);
    chk("tmo_sticky", bus.TMO, 1'b1);
`else
    chk("tmo_tied", bus.TMO, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
